// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        TRAP = 2'd1,
        BR   = 2'd2,
        RET  = 2'd3
    } redirect_cause_e;

    localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer addressed by a top pointer.
// A push into a full stack silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    tp;
    logic [CW-1:0]    cnt;
    logic             pop_eff;
    logic [PW-1:0]    wr_idx;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign top     = mem[tp];
    assign count   = cnt;
    assign pop_eff = pop & ~empty;

    // Push with a live pop replaces the top in place
    assign wr_idx = pop_eff ? tp : tp + PW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp  <= '0;
            cnt <= '0;
        end else if (push && !pop_eff) begin
            tp <= tp + PW'(1);
            if (!full) begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop_eff && !push) begin
            tp  <= tp - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: valid/ready handshake, stall, prioritised
// redirects with alignment check, and an internal return-address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4,
    parameter int              INSN_BYTES   = pc_pkg::INSN_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [XLEN-1:0]            pc,
    input  logic                       trap_valid,
    input  logic [XLEN-1:0]            trap_vec,
    input  logic                       br_valid,
    input  logic [XLEN-1:0]            br_target,
    input  logic                       call_push,
    input  logic [XLEN-1:0]            push_addr,
    input  logic                       ret_pop,
    input  logic [XLEN-1:0]            ret_fallback,
    output logic                       misalign,
    output logic [1:0]                 redirect_cause,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_n;
    logic            fv_q;
    logic            mis_q;
    logic            mis_n;
    redirect_cause_e cause_q;
    redirect_cause_e cause_n;

    logic            fire;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic [XLEN-1:0] ret_tgt;

    assign fire    = fv_q & fetch_ready & ~stall;
    assign ret_tgt = ras_empty ? ret_fallback : ras_top;

    always_comb begin
        pc_n    = pc_q;
        cause_n = cause_q;
        mis_n   = 1'b0;
        ras_pop = 1'b0;
        if (trap_valid) begin
            pc_n    = trap_vec;
            cause_n = TRAP;
        end else if (br_valid) begin
            if (br_target[1:0] != 2'b00) begin
                pc_n    = trap_vec;
                cause_n = TRAP;
                mis_n   = 1'b1;
            end else begin
                pc_n    = br_target;
                cause_n = BR;
            end
        end else if (ret_pop) begin
            // The pop happens even when the target is diverted to the trap
            ras_pop = 1'b1;
            if (ret_tgt[1:0] != 2'b00) begin
                pc_n    = trap_vec;
                cause_n = TRAP;
                mis_n   = 1'b1;
            end else begin
                pc_n    = ret_tgt;
                cause_n = RET;
            end
        end else if (fire) begin
            pc_n    = pc_q + XLEN'(INSN_BYTES);
            cause_n = SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            fv_q    <= 1'b0;
            mis_q   <= 1'b0;
            cause_q <= SEQ;
        end else begin
            pc_q    <= pc_n;
            fv_q    <= 1'b1;
            mis_q   <= mis_n;
            cause_q <= cause_n;
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (call_push),
        .pop       (ras_pop),
        .push_data (push_addr),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc             = pc_q;
    assign fetch_valid    = fv_q;
    assign misalign       = mis_q;
    assign redirect_cause = cause_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        br_valid;
    logic [31:0] br_target;
    logic        call_push;
    logic [31:0] push_addr;
    logic        ret_pop;
    logic [31:0] ret_fallback;
    logic        misalign;
    logic [1:0]  redirect_cause;
    logic [2:0]  ras_count;

    int n_chk = 0;
    int n_pass = 0;

    // Reference state
    logic [31:0] m_pc;
    logic        m_fv;
    logic        m_mis;
    logic [1:0]  m_cause;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (4),
        .INSN_BYTES   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .pc             (pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .br_valid       (br_valid),
        .br_target      (br_target),
        .call_push      (call_push),
        .push_addr      (push_addr),
        .ret_pop        (ret_pop),
        .ret_fallback   (ret_fallback),
        .misalign       (misalign),
        .redirect_cause (redirect_cause),
        .ras_count      (ras_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Next model state from the current inputs
    task automatic model_step();
        logic [31:0] tgt;
        logic        fire;
        fire = m_fv && fetch_ready && !stall;
        if (rst) begin
            m_pc = 32'h0; m_fv = 0; m_mis = 0; m_cause = 0;
            m_ras.delete();
            return;
        end
        m_mis = 0;
        if (trap_valid) begin
            m_pc = trap_vec; m_cause = 1;
        end else if (br_valid) begin
            if (br_target % 4 != 0) begin
                m_pc = trap_vec; m_cause = 1; m_mis = 1;
            end else begin
                m_pc = br_target; m_cause = 2;
            end
        end else if (ret_pop) begin
            if (m_ras.size() > 0) tgt = m_ras.pop_front();
            else tgt = ret_fallback;
            if (tgt % 4 != 0) begin
                m_pc = trap_vec; m_cause = 1; m_mis = 1;
            end else begin
                m_pc = tgt; m_cause = 3;
            end
        end else if (fire) begin
            m_pc = m_pc + 32'd4; m_cause = 0;
        end
        if (call_push) begin
            m_ras.push_front(push_addr);
            if (m_ras.size() > 4) void'(m_ras.pop_back());
        end
        m_fv = 1;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        check("misalign", 32'(misalign), 32'(m_mis));
        check("cause", 32'(redirect_cause), 32'(m_cause));
        check("ras_count", 32'(ras_count), m_ras.size());
    endtask

    task automatic idle();
        rst = 0; stall = 0; fetch_ready = 1;
        trap_valid = 0; br_valid = 0; call_push = 0; ret_pop = 0;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 4) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    logic [31:0] pop_pc[5];
    logic [31:0] pop_cnt[5];

    initial begin
        idle();
        trap_vec = 32'h100; br_target = 0; push_addr = 0;
        ret_fallback = 32'h200;
        m_pc = 0; m_fv = 0; m_mis = 0; m_cause = 0;

        // Reset and start-up
        rst = 1;
        cyc(); cyc();
        check("rst_pc", pc, 32'h0);
        check("rst_fv", 32'(fetch_valid), 32'h0);
        rst = 0;
        cyc();
        check("start_pc", pc, 32'h0);
        check("start_fv", 32'(fetch_valid), 32'h1);
        cyc(); cyc();
        check("seq_pc8", pc, 32'h8);

        // Back-pressure and stall
        fetch_ready = 0;
        repeat (3) cyc();
        check("hold_ready", pc, 32'h8);
        fetch_ready = 1;
        cyc();
        check("release_pc", pc, 32'hC);
        stall = 1;
        repeat (3) cyc();
        check("hold_stall", pc, 32'hC);
        stall = 0;
        cyc();
        check("unstall_pc", pc, 32'h10);

        // Trap beats branch
        trap_valid = 1; br_valid = 1; br_target = 32'h40;
        cyc();
        check("trap_pc", pc, 32'h100);
        check("trap_cause", 32'(redirect_cause), 32'd1);
        idle();

        // Misaligned branch
        br_valid = 1; br_target = 32'h42;
        cyc();
        check("mis_pc", pc, 32'h100);
        check("mis_pulse", 32'(misalign), 32'd1);
        idle();
        cyc();
        check("mis_clear", 32'(misalign), 32'd0);

        // RAS overflow then drain
        for (int i = 1; i <= 5; i++) begin
            call_push = 1; push_addr = 32'(i * 16);
            cyc();
        end
        idle();
        check("ras_full", 32'(ras_count), 32'd4);
        pop_pc  = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h200};
        pop_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            ret_pop = 1;
            cyc();
            check("pop_pc", pc, pop_pc[i]);
            check("pop_cnt", 32'(ras_count), pop_cnt[i]);
        end
        idle();

        // Address wrap
        br_valid = 1; br_target = 32'hFFFF_FFFC;
        cyc();
        idle();
        cyc();
        check("wrap_pc", pc, 32'h0);

        // Reset during a pop
        call_push = 1; push_addr = 32'h80;
        cyc(); cyc();
        idle();
        ret_pop = 1; rst = 1;
        cyc();
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_cnt", 32'(ras_count), 32'd0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            fetch_ready  = ($urandom_range(0, 3) != 0);
            trap_valid   = ($urandom_range(0, 19) == 0);
            br_valid     = ($urandom_range(0, 7) == 0);
            ret_pop      = ($urandom_range(0, 5) == 0);
            call_push    = ($urandom_range(0, 4) == 0);
            trap_vec     = {$urandom_range(0, 255), 2'b00};
            br_target    = rnd_tgt();
            push_addr    = rnd_tgt();
            ret_fallback = rnd_tgt();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
